// File: rtl/dsp_accum.sv
// Signed multiply-accumulate for the fit unit: a constant word loads ACC, product words add to it,
// and the last word of an event produces one scaled, saturated RESULT.
module dsp_accum #(
    parameter int CW   = 18,
    parameter int XW   = 12,
    parameter int AW   = 48,
    parameter int OW   = 32,
    parameter int FRAC = 0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          MODECP,
    input  logic          FREEZE,
    input  logic          DVout,
    input  logic [CW-1:0] COEF,
    input  logic [XW-1:0] COORD,
    output logic [OW-1:0] RESULT,
    output logic          RESULT_VALID,
    output logic          OVERFLOW
);
    localparam int PW     = CW + XW;
    localparam int STAGES = 3;

    // vld_pipe[k]: word held at stage k is unfrozen; lst_pipe[k]: it ends the event
    logic [STAGES:1]       vld_pipe;
    logic [STAGES:1]       lst_pipe;
    logic                  s1_mode, s2_mode;
    logic signed [CW-1:0]  s1_coef;
    logic signed [XW-1:0]  s1_coord;
    logic signed [PW-1:0]  s2_val;
    logic signed [AW-1:0]  acc;
    logic                  sticky;

    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  coef_ext;
    logic signed [AW-1:0]  s2_ext;
    logic signed [AW-1:0]  acc_sum;
    logic                  add_ovf;
    logic signed [AW-1:0]  t_shift;
    logic [AW-OW:0]        t_hi;
    logic                  in_range;
    logic [OW-1:0]         res_sat;
    logic                  fire;

    always_comb begin
        prod     = s1_coef * s1_coord;
        coef_ext = {{XW{s1_coef[CW-1]}}, s1_coef};
        s2_ext   = {{(AW-PW){s2_val[PW-1]}}, s2_val};
        acc_sum  = acc + s2_ext;
        add_ovf  = (acc[AW-1] == s2_ext[AW-1]) && (acc_sum[AW-1] != acc[AW-1]);
        t_shift  = acc >>> FRAC;
        // T fits in OW bits only if its top AW-OW+1 bits are all copies of the sign
        t_hi     = t_shift[AW-1:OW-1];
        in_range = (&t_hi) | ~(|t_hi);
        if (in_range)
            res_sat = t_shift[OW-1:0];
        else if (t_shift[AW-1])
            res_sat = {1'b1, {(OW-1){1'b0}}};
        else
            res_sat = {1'b0, {(OW-1){1'b1}}};
        fire     = vld_pipe[STAGES] & lst_pipe[STAGES];
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            vld_pipe     <= '0;
            lst_pipe     <= '0;
            s1_mode      <= 1'b0;
            s2_mode      <= 1'b0;
            s1_coef      <= '0;
            s1_coord     <= '0;
            s2_val       <= '0;
            acc          <= '0;
            sticky       <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            OVERFLOW     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], ~FREEZE};
            lst_pipe <= {lst_pipe[STAGES-1:1], DVout};
            s1_mode  <= MODECP;
            s1_coef  <= COEF;
            s1_coord <= COORD;
            s2_mode  <= s1_mode;
            // the constant rides the product path so S3 sees a single operand
            s2_val   <= s1_mode ? coef_ext : prod;
            if (vld_pipe[2]) begin
                if (s2_mode) begin
                    acc    <= s2_ext;
                    sticky <= 1'b0;
                end else begin
                    acc    <= acc_sum;
                    sticky <= sticky | add_ovf;
                end
            end
            RESULT_VALID <= fire;
            if (fire) begin
                RESULT   <= res_sat;
                OVERFLOW <= ~in_range | sticky;
            end
        end
    end
endmodule

// File: tb/tb_dsp_accum.sv
// Randomized + directed scoreboard bench for dsp_accum, run on three parameter sets
// (OW=32/FRAC=0, OW=16/FRAC=0, OW=32/FRAC=4) sharing one input stream.
module tb_dsp_accum;
    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        MODECP, FREEZE, DVout;
    logic [17:0] COEF;
    logic [11:0] COORD;
    logic [31:0] r0, r2;
    logic [15:0] r1;
    logic        v0, v1, v2, o0, o1, o2;

    dsp_accum #(.OW(32), .FRAC(0)) u_d0 (.CLOCK(CLOCK), .RESET(RESET), .MODECP(MODECP), .FREEZE(FREEZE),
        .DVout(DVout), .COEF(COEF), .COORD(COORD), .RESULT(r0), .RESULT_VALID(v0), .OVERFLOW(o0));
    dsp_accum #(.OW(16), .FRAC(0)) u_d1 (.CLOCK(CLOCK), .RESET(RESET), .MODECP(MODECP), .FREEZE(FREEZE),
        .DVout(DVout), .COEF(COEF), .COORD(COORD), .RESULT(r1), .RESULT_VALID(v1), .OVERFLOW(o1));
    dsp_accum #(.OW(32), .FRAC(4)) u_d2 (.CLOCK(CLOCK), .RESET(RESET), .MODECP(MODECP), .FREEZE(FREEZE),
        .DVout(DVout), .COEF(COEF), .COORD(COORD), .RESULT(r2), .RESULT_VALID(v2), .OVERFLOW(o2));

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        longint res;
        longint ovf;
        int     cyc;
    } exp_t;

    localparam int OWS[3]   = '{32, 16, 32};
    localparam int FRACS[3] = '{0, 0, 4};

    exp_t   sb[3][$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    bit     rst_q = 1'b1;
    longint macc = 0;
    bit     msticky = 0;
    longint last_res[3];
    longint last_ovf[3];
    longint ar[3];
    bit     av[3];
    longint ao[3];

    always @(posedge CLOCK) begin
        cyc++;
        rst_q <= RESET;
    end

    task automatic chk(input string nm, input int i, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", nm, i, cyc, act, req);
        end
    endtask

    function automatic longint wrap48(input longint v);
        logic signed [47:0] t;
        t = v[47:0];
        return longint'(t);
    endfunction

    // Reference: event value is plain integer arithmetic, then shifted and clamped per config
    task automatic push_exp();
        for (int i = 0; i < 3; i++) begin
            longint t, maxv, minv;
            exp_t   e;
            t    = macc >>> FRACS[i];
            maxv = (longint'(1) <<< (OWS[i] - 1)) - 1;
            minv = -maxv - 1;
            e.ovf = msticky ? 1 : 0;
            if (t > maxv) begin
                e.res = maxv; e.ovf = 1;
            end else if (t < minv) begin
                e.res = minv; e.ovf = 1;
            end else begin
                e.res = t;
            end
            e.cyc = cyc + 4;
            sb[i].push_back(e);
        end
    endtask

    task automatic word(input bit m, input bit f, input bit l, input int c, input int x);
        longint cv, xv, s, w;
        @(negedge CLOCK);
        MODECP = m; FREEZE = f; DVout = l;
        COEF = 18'(c); COORD = 12'(x);
        if (!f) begin
            cv = longint'($signed(COEF));
            xv = longint'($signed(COORD));
            if (m) begin
                macc = cv; msticky = 0;
            end else begin
                s = macc + cv * xv;
                w = wrap48(s);
                if (w != s) msticky = 1;
                macc = w;
            end
            if (l) push_exp();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) word($urandom_range(0, 1), 1, $urandom_range(0, 1), $urandom, $urandom);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1; FREEZE = 1'b1;
        macc = 0; msticky = 0;
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each strobe; between strobes outputs must hold
    always @(negedge CLOCK) begin
        ar[0] = longint'($signed(r0)); av[0] = (v0 === 1'b1); ao[0] = (o0 === 1'b1) ? 1 : 0;
        ar[1] = longint'($signed(r1)); av[1] = (v1 === 1'b1); ao[1] = (o1 === 1'b1) ? 1 : 0;
        ar[2] = longint'($signed(r2)); av[2] = (v2 === 1'b1); ao[2] = (o2 === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            if (rst_q) begin
                sb[i].delete();
                last_res[i] = 0;
                last_ovf[i] = 0;
            end
            if (av[i]) begin
                if (sb[i].size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_strobe dut%0d cyc=%0d got=%0d expected=none", i, cyc, ar[i]);
                end else begin
                    exp_t e;
                    e = sb[i].pop_front();
                    chk("result", i, ar[i], e.res);
                    chk("overflow", i, ao[i], e.ovf);
                    chk("latency", i, cyc, e.cyc);
                    last_res[i] = e.res;
                    last_ovf[i] = e.ovf;
                end
            end else begin
                if (sb[i].size() != 0 && sb[i][0].cyc <= cyc) begin
                    checks++; failures++;
                    $display("FAIL missing_strobe dut%0d cyc=%0d got=none expected=%0d", i, cyc, sb[i][0].res);
                    void'(sb[i].pop_front());
                end
                chk("hold_result", i, ar[i], last_res[i]);
                chk("hold_overflow", i, ao[i], last_ovf[i]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; FREEZE = 1'b1; MODECP = 1'b0; DVout = 1'b0; COEF = '0; COORD = '0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        idle(2);

        // nominal: 100 + 12 - 30 - 14 = 68
        word(1, 0, 0, 100, 0); word(0, 0, 0, 3, 4); word(0, 0, 0, -5, 6); word(0, 0, 1, 7, -2);
        idle(6);
        // same event with frozen junk words in between
        word(1, 0, 0, 100, 0); word(0, 0, 0, 3, 4); word(1, 1, 1, 999, 999);
        word(0, 0, 0, -5, 6); word(1, 1, 1, 999, 999); word(0, 0, 1, 7, -2);
        idle(6);
        // back-to-back: 16 then -21
        word(1, 0, 0, 10, 0); word(0, 0, 1, 2, 3); word(1, 0, 0, -1, 0); word(0, 0, 1, -4, 5);
        idle(6);
        // 40000 saturates the 16-bit config, then a clean single-word event
        word(1, 0, 0, 30000, 0); word(0, 0, 1, 100, 100); word(1, 0, 1, 1, 0);
        idle(6);
        word(1, 0, 0, -30000, 0); word(0, 0, 1, -100, 100);
        idle(6);
        // single-word events every cycle; -33 >>> 4 = -3
        word(1, 0, 1, -33, 0); word(1, 0, 1, 12345, 0); word(1, 0, 1, -131072, 0);
        idle(6);
        // reset right after a last word: its result must never appear
        word(1, 0, 0, 7, 0); word(0, 0, 1, 2, 3);
        do_reset();
        idle(6);
        word(1, 0, 1, 5, 0);
        idle(6);
        // product-only event accumulates onto ACC=0 after reset
        do_reset();
        word(0, 0, 1, 2, 3);
        idle(6);

        repeat (200) begin
            int  n;
            bit  has_c;
            n     = $urandom_range(0, 6);
            has_c = ($urandom_range(0, 7) != 0) || (n == 0);
            if (has_c) word(1, 0, n == 0, $urandom, $urandom);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                word(0, 0, k == n - 1, $urandom, $urandom);
            end
            idle($urandom_range(0, 2));
        end

        idle(8);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sb[i].size() != 0) begin
                failures++;
                $display("FAIL drain dut%0d got=%0d pending expected=0", i, sb[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dsp_accum.md
# dsp_accum

Signed multiply-accumulate datapath driven by the DSP sequencing controller in the GigaFitter fit unit. Per event it loads a constant term, then accumulates coefficient × coordinate products, and emits one scaled, saturated result per event. Its control inputs (mode, freeze, end-of-event valid) come directly from the controller. Its result feeds the fit-parameter / chi-square collection stage.

## Interface
- CW, 18: coefficient width (signed two's complement)
- XW, 12: coordinate width (signed two's complement)
- AW, 48: accumulator width; must be ≥ CW+XW+4
- OW, 32: result width (signed)
- FRAC, 0: arithmetic right shift applied to the accumulator before output
- CLOCK  in  1: the single clock. All state changes on its rising edge.
- RESET  in  1: synchronous, active-high reset.
- MODECP  in  1: 1 = constant word (load), 0 = product word (accumulate).
- FREEZE  in  1: 1 = the current word is invalid; accumulator holds.
- DVout  in  1: marks the last word of the event (end-of-event valid).
- COEF  in  CW: coefficient, or the constant term when MODECP=1.
- COORD  in  XW: coordinate. Ignored when MODECP=1.
- RESULT  out  OW: final event sum.
- RESULT_VALID  out  1: one-cycle strobe; RESULT is valid while it is high.
- OVERFLOW  out  1: saturation/overflow flag for the current RESULT. Valid with RESULT_VALID.

## Operation
- No stall or back-pressure. A word is presented every cycle; FREEZE only qualifies it.
- The integrator aligns MODECP, FREEZE, DVout, COEF and COORD to the same cycle.
- The pipeline has three stages, and each word carries its qualifiers (mode, freeze, last) through them:
  - S1: register the inputs.
  - S2: P = COEF*COORD, full CW+XW bits, signed.
  - S3: accumulator update.
- Accumulator update, in priority order:
  - Frozen word: ACC and the sticky overflow bit hold.
  - MODECP=1: ACC ← sext(COEF); the sticky overflow bit clears.
  - Otherwise: ACC ← ACC + sext(P). If the AW-bit signed add overflows, ACC wraps and the sticky overflow bit sets.
- FREEZE=1 overrides MODECP and DVout: the word is dropped entirely, and DVout on a frozen word produces no result.
- Output stage, one cycle after S3 accumulates a word whose last=1:
  - T = ACC >>> FRAC.
  - If T is outside the OW signed range, RESULT saturates to +2^(OW-1)-1 or -2^(OW-1), and OVERFLOW=1.
  - OVERFLOW also = 1 if the sticky overflow bit is set.
  - RESULT_VALID=1 for exactly one cycle.
- RESULT and OVERFLOW hold their last values until the next result strobe.
- A single-word event (MODECP=1 and DVout=1 together) gives RESULT = constant.
- Product words with no preceding constant (e.g. after reset) accumulate onto ACC=0.
- Back-to-back events: a constant word on the cycle right after a last word is legal. No bubble is required.

## Timing
- Reset values: RESULT=0, RESULT_VALID=0, OVERFLOW=0, ACC=0, sticky overflow bit=0, all pipeline qualifiers cleared.
- RESET asserted mid-event discards all in-flight words. No RESULT_VALID is produced for them, including for any last word already in the pipeline.
- Latency: a last word sampled at edge E0 gives RESULT_VALID high during the cycle after edge E0+3. Fixed; independent of FREEZE gaps earlier in the event.
- Throughput: one word per cycle, one result per event, a new result possible every cycle (single-word events).
- The constant word of event N+1 never disturbs event N's result: RESULT is captured from ACC at the edge where S3 holds event N's last word.

## Test plan
- Nominal event, FRAC=0:
  - Stimulus: constant 100; products (3,4), (-5,6), (7,-2) with DVout on the last word.
  - Required: RESULT=100+12-30-14=68, OVERFLOW=0, RESULT_VALID one cycle, 4 cycles after the last word's edge.
- FREEZE gaps:
  - Stimulus: the same event with FREEZE=1 on two cycles between products. Frozen cycles carry COEF=999, COORD=999, MODECP=1, DVout=1.
  - Required: RESULT=68, a single strobe, frozen words ignored.
- Back-to-back events:
  - Stimulus: event A (constant 10, product 2×3, last); next cycle event B (constant -1, product -4×5, last).
  - Required: strobes on consecutive-event timing, RESULT=16 then -21.
- Saturation:
  - Setup: OW=16, FRAC=0.
  - Stimulus: constant 30000 plus product 100×100.
  - Required: RESULT=32767, OVERFLOW=1.
  - Follow-up: the next event (constant 1, last) gives OVERFLOW=0, RESULT=1.
- Reset mid-event:
  - Stimulus: assert RESET one cycle after a last word is sampled.
  - Required: no RESULT_VALID; RESULT=0, OVERFLOW=0.
  - Follow-up: a following event (constant 5, last) gives RESULT=5.
- FRAC shift:
  - Setup: FRAC=4.
  - Stimulus: constant -33, last.
  - Required: RESULT=-3 (arithmetic shift, floor).
